// File: rtl/load_store_unit.sv
// RV32I load/store unit: turns byte-addressed LB..SW requests into word-addressed
// memory accesses and returns aligned, extended load data as a one-cycle response.
module load_store_unit #(
  parameter int MEM_READ_LATENCY = 1,
  parameter int IO_READ_LATENCY  = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_address,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [11:0] mem_address,
  output logic [3:0]  mem_byteena,
  output logic [31:0] mem_data,
  output logic        mem_wren,
  input  logic [31:0] mem_q
);
  localparam int NUM_LANES = 4;
  localparam int CW        = 8;

  typedef enum logic {IDLE, WAIT} state_t;
  typedef struct packed {
    logic [11:0] addr;
    logic [2:0]  funct3;
    logic [1:0]  off;
  } hold_t;

  state_t          state;
  hold_t           hold_q;
  logic [CW-1:0]   cnt;
  logic [1:0]      off;
  logic            funct_ok, misalign, legal;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;
  logic [31:0]     load_ext;
  logic [NUM_LANES-1:0][7:0] lane_data;
  logic            unused_addr;

  assign unused_addr = ^req_address[31:14];
  assign off         = req_address[1:0];
  assign req_ready   = (state == IDLE);
  assign mem_address = (state == IDLE) ? req_address[13:2] : hold_q.addr;

  always_comb begin
    funct_ok = req_write ? (req_funct3 inside {3'b000, 3'b001, 3'b010})
                         : (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misalign = ((req_funct3[1:0] == 2'b01) && off[0]) ||
               ((req_funct3[1:0] == 2'b10) && (off != 2'b00));
    legal    = funct_ok && !misalign;
  end

  // Each byte lane picks the store byte that would land on it for the access size.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lane_data[i] = (req_funct3[1:0] == 2'b00) ? req_wdata[7:0] :
                          (req_funct3[1:0] == 2'b01) ? req_wdata[8*(i%2) +: 8] :
                                                       req_wdata[8*i +: 8];
  end
  assign mem_data = lane_data;

  always_comb begin
    mem_byteena = 4'b1111;
    if (state == IDLE && req_write) begin
      case (req_funct3[1:0])
        2'b00:   mem_byteena = 4'b0001 << off;
        2'b01:   mem_byteena = 4'b0011 << off;
        default: mem_byteena = 4'b1111;
      endcase
    end
  end

  assign mem_wren = !reset && (state == IDLE) && req_valid && req_write && legal;

  always_comb begin
    byte_v = mem_q[{hold_q.off, 3'b000} +: 8];
    half_v = mem_q[{hold_q.off[1], 4'b0000} +: 16];
    case (hold_q.funct3[1:0])
      2'b00:   load_ext = {{24{byte_v[7] & ~hold_q.funct3[2]}}, byte_v};
      2'b01:   load_ext = {{16{half_v[15] & ~hold_q.funct3[2]}}, half_v};
      default: load_ext = mem_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      hold_q     <= '0;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          if (!legal || req_write) begin
            // Errors and stores complete without leaving IDLE.
            resp_valid <= 1'b1;
            resp_error <= !legal;
            resp_rdata <= '0;
          end else begin
            hold_q <= '{addr: req_address[13:2], funct3: req_funct3, off: off};
            cnt    <= req_address[12] ? CW'(IO_READ_LATENCY - 1) : CW'(MEM_READ_LATENCY - 1);
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            resp_valid <= 1'b1;
            resp_error <= 1'b0;
            resp_rdata <= load_ext;
            state      <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stores, RAM/IO loads, extension, errors, reset abort.
module tb_load_store_unit;
  logic        clock = 0;
  logic        reset = 1;
  logic        req_valid = 0, req_write = 0;
  logic [2:0]  req_funct3 = 0;
  logic [31:0] req_address = 0, req_wdata = 0, mem_q = 0;
  logic        req_ready, resp_valid, resp_error, mem_wren;
  logic [31:0] resp_rdata, mem_data;
  logic [11:0] mem_address;
  logic [3:0]  mem_byteena;
  int tests = 0, fails = 0;

  load_store_unit dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_funct3(req_funct3), .req_address(req_address),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .mem_address(mem_address), .mem_byteena(mem_byteena),
    .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic drive(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    @(negedge clock);
    req_valid = 1; req_write = w; req_funct3 = f3; req_address = a; req_wdata = d;
    #1;
  endtask

  task automatic test_reset();
    drive(1, 3'b010, 32'h100, 32'h12345678);
    tests++; if (mem_wren !== 1'b0) begin fails++; $display("FAIL reset_wren got %b exp 0", mem_wren); end
    @(posedge clock); #1;
    tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", resp_valid); end
    tests++; if (resp_rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata got %h exp 0", resp_rdata); end
    tests++; if (resp_error !== 1'b0) begin fails++; $display("FAIL reset_error got %b exp 0", resp_error); end
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", req_ready); end
    req_valid = 0; reset = 0;
  endtask

  task automatic test_store_sw();
    drive(1, 3'b010, 32'h100, 32'hDEADBEEF);
    tests++; if (mem_wren !== 1'b1) begin fails++; $display("FAIL sw_wren got %b exp 1", mem_wren); end
    tests++; if (mem_byteena !== 4'b1111) begin fails++; $display("FAIL sw_be got %b exp 1111", mem_byteena); end
    tests++; if (mem_address !== 12'h040) begin fails++; $display("FAIL sw_addr got %h exp 040", mem_address); end
    tests++; if (mem_data !== 32'hDEADBEEF) begin fails++; $display("FAIL sw_data got %h exp deadbeef", mem_data); end
    @(posedge clock); #1; req_valid = 0; #1;
    tests++; if (mem_wren !== 1'b0) begin fails++; $display("FAIL sw_wren_after got %b exp 0", mem_wren); end
    tests++; if (resp_valid !== 1'b1 || resp_error !== 1'b0 || resp_rdata !== 32'h0) begin
      fails++; $display("FAIL sw_resp got v=%b e=%b d=%h exp v=1 e=0 d=0", resp_valid, resp_error, resp_rdata); end
    @(posedge clock); #1;
    tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL sw_pulse got %b exp 0", resp_valid); end
  endtask

  task automatic test_back_to_back();
    drive(1, 3'b000, 32'h103, 32'hFFFFFF80);
    tests++; if (mem_byteena !== 4'b1000 || mem_data !== 32'h80808080 || mem_wren !== 1'b1) begin
      fails++; $display("FAIL sb_lanes got be=%b d=%h w=%b exp be=1000 d=80808080 w=1", mem_byteena, mem_data, mem_wren); end
    @(posedge clock);
    drive(1, 3'b001, 32'h102, 32'hAAAA1234);
    tests++; if (resp_valid !== 1'b1 || req_ready !== 1'b1) begin
      fails++; $display("FAIL b2b_overlap got v=%b r=%b exp v=1 r=1", resp_valid, req_ready); end
    tests++; if (mem_byteena !== 4'b1100 || mem_data !== 32'h12341234 || mem_wren !== 1'b1) begin
      fails++; $display("FAIL sh_lanes got be=%b d=%h w=%b exp be=1100 d=12341234 w=1", mem_byteena, mem_data, mem_wren); end
    @(posedge clock); #1; req_valid = 0;
    tests++; if (resp_valid !== 1'b1 || resp_error !== 1'b0) begin
      fails++; $display("FAIL b2b_second got v=%b e=%b exp v=1 e=0", resp_valid, resp_error); end
    @(posedge clock); #1;
  endtask

  task automatic test_ram_loads();
    logic [2:0]  f3s [8] = '{3'b010, 3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b001, 3'b100};
    logic [31:0] adr [8] = '{32'h100, 32'h103, 32'h103, 32'h102, 32'h102, 32'h100, 32'h100, 32'h101};
    logic [31:0] qs  [8] = '{32'hDEADBEEF, 32'h80112233, 32'h80112233, 32'h80015555,
                             32'h80015555, 32'h1122337F, 32'h0000F00F, 32'h0000A500};
    logic [31:0] exp [8] = '{32'hDEADBEEF, 32'hFFFFFF80, 32'h00000080, 32'hFFFF8001,
                             32'h00008001, 32'h0000007F, 32'hFFFFF00F, 32'h000000A5};
    for (int i = 0; i < 8; i++) begin
      mem_q = 32'h0;
      drive(0, f3s[i], adr[i], 32'h0);
      tests++; if (mem_wren !== 1'b0 || mem_byteena !== 4'b1111 || mem_address !== 12'h040) begin
        fails++; $display("FAIL ld%0d_req got w=%b be=%b a=%h exp w=0 be=1111 a=040", i, mem_wren, mem_byteena, mem_address); end
      @(posedge clock); #1;
      req_valid = 0; req_address = 32'h0; mem_q = qs[i]; #1;
      tests++; if (req_ready !== 1'b0 || resp_valid !== 1'b0 || mem_address !== 12'h040) begin
        fails++; $display("FAIL ld%0d_wait got r=%b v=%b a=%h exp r=0 v=0 a=040", i, req_ready, resp_valid, mem_address); end
      @(posedge clock); #1;
      tests++; if (resp_valid !== 1'b1 || resp_rdata !== exp[i] || resp_error !== 1'b0 || req_ready !== 1'b1) begin
        fails++; $display("FAIL ld%0d_resp got v=%b d=%h e=%b r=%b exp v=1 d=%h e=0 r=1", i, resp_valid, resp_rdata, resp_error, req_ready, exp[i]); end
    end
    @(posedge clock); #1;
    tests++; if (resp_valid !== 1'b0 || resp_rdata !== 32'h000000A5) begin
      fails++; $display("FAIL ld_hold got v=%b d=%h exp v=0 d=000000a5", resp_valid, resp_rdata); end
  endtask

  task automatic test_errors();
    logic        ws  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [2:0]  f3s [4] = '{3'b010, 3'b011, 3'b001, 3'b110};
    logic [31:0] adr [4] = '{32'h1001, 32'h100, 32'h101, 32'h100};
    for (int i = 0; i < 4; i++) begin
      drive(ws[i], f3s[i], adr[i], 32'hCAFEF00D);
      tests++; if (mem_wren !== 1'b0) begin fails++; $display("FAIL err%0d_wren got %b exp 0", i, mem_wren); end
      @(posedge clock); #1; req_valid = 0;
      tests++; if (resp_valid !== 1'b1 || resp_error !== 1'b1 || resp_rdata !== 32'h0 || req_ready !== 1'b1) begin
        fails++; $display("FAIL err%0d_resp got v=%b e=%b d=%h r=%b exp v=1 e=1 d=0 r=1", i, resp_valid, resp_error, resp_rdata, req_ready); end
    end
    @(posedge clock); #1;
    tests++; if (resp_valid !== 1'b0 || resp_error !== 1'b1) begin
      fails++; $display("FAIL err_hold got v=%b e=%b exp v=0 e=1", resp_valid, resp_error); end
  endtask

  task automatic test_io_load();
    mem_q = 32'h0;
    drive(0, 3'b010, 32'h1000, 32'h0);
    tests++; if (mem_address !== 12'h400) begin fails++; $display("FAIL io_addr got %h exp 400", mem_address); end
    @(posedge clock); #1;
    req_valid = 0; req_address = 32'h0; mem_q = 32'h00000BAD; #1;
    tests++; if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin
      fails++; $display("FAIL io_wait1 got r=%b v=%b exp r=0 v=0", req_ready, resp_valid); end
    @(posedge clock); #1;
    mem_q = 32'h000003FF;
    tests++; if (req_ready !== 1'b0 || resp_valid !== 1'b0 || mem_address !== 12'h400) begin
      fails++; $display("FAIL io_wait2 got r=%b v=%b a=%h exp r=0 v=0 a=400", req_ready, resp_valid, mem_address); end
    @(posedge clock); #1;
    tests++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h000003FF || resp_error !== 1'b0 || req_ready !== 1'b1) begin
      fails++; $display("FAIL io_resp got v=%b d=%h e=%b r=%b exp v=1 d=000003ff e=0 r=1", resp_valid, resp_rdata, resp_error, req_ready); end
    @(posedge clock); #1;
    tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL io_pulse got %b exp 0", resp_valid); end
  endtask

  task automatic test_reset_abort();
    int seen;
    mem_q = 32'h000003FF;
    drive(0, 3'b010, 32'h1000, 32'h0);
    @(posedge clock); #1;
    req_valid = 0; reset = 1;
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL abort_wait got %b exp 0", req_ready); end
    @(posedge clock); #1;
    seen = resp_valid;
    tests++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      fails++; $display("FAIL abort_idle got r=%b v=%b exp r=1 v=0", req_ready, resp_valid); end
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      if (resp_valid) seen++;
    end
    tests++; if (seen !== 0) begin fails++; $display("FAIL abort_noresp got %0d pulses exp 0", seen); end
  endtask

  initial begin
    test_reset();
    test_store_sw();
    test_back_to_back();
    test_ram_loads();
    test_errors();
    test_io_load();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the RV32I execute stage and the data memory / memory-mapped IO block.
- Converts RV32I load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into word-addressed memory accesses:
  - 12-bit word address, 4-bit byte enable, lane-replicated write data, write enable.
- Waits out the read latency, which differs between RAM and the IO read window.
- Returns aligned, sign/zero-extended load data through a valid/ready request and a one-cycle response pulse.

Parameters:
- MEM_READ_LATENCY, 1, clock edges from request accept to the edge where RAM read data (mem_q) is captured.
- IO_READ_LATENCY, 2, clock edges from request accept to the edge where IO read data is captured (word address bit 10 set).

Ports:
- clock  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request this cycle
- req_write  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32I funct3 of the load/store
- req_address  input  32  byte address
- req_wdata  input  32  store data (rs2)
- resp_valid  output  1  one-cycle completion pulse (loads, stores and errors)
- resp_rdata  output  32  extended load data; 0 for stores and errors
- resp_error  output  1  misaligned or illegal funct3; valid with resp_valid
- mem_address  output  12  word address = byte address [13:2]
- mem_byteena  output  4  byte lane enables
- mem_data  output  32  lane-replicated write data
- mem_wren  output  1  write strobe
- mem_q  input  32  read data from memory/IO block

Behaviour:
- Reset (synchronous): state IDLE; resp_valid 0, resp_rdata 0, resp_error 0. mem_wren is forced 0 while reset is high. Reset during WAIT aborts the load: no resp_valid is ever produced for it.
- States:
  - IDLE: req_ready = 1.
  - WAIT: req_ready = 0; holds address, funct3 and byte offset in registers, plus a latency down-counter.
- Accept: an edge where req_valid && req_ready.
- Address/lane mapping:
  - In IDLE, mem_address = req_address[13:2] (combinational); in WAIT it is the held value and stays stable until capture.
  - Byte offset off = req_address[1:0].
- Legality:
  - Loads legal for funct3 000/001/010/100/101; stores legal for 000/001/010.
  - Halfword is misaligned if off[0] = 1; word is misaligned if off != 0.
  - Any illegal or misaligned request: no memory access (mem_wren 0); resp_valid = 1 and resp_error = 1 in the cycle after accept; resp_rdata = 0; stays in IDLE.
- Store (legal):
  - mem_wren = 1 combinationally in the accept cycle only.
  - SB: byteena = 0001 << off; data = four copies of wdata[7:0].
  - SH: byteena = 0011 << off; data = two copies of wdata[15:0].
  - SW: byteena = 1111; data = wdata.
  - resp_valid pulses in the next cycle with rdata 0, error 0; stays in IDLE, so back-to-back stores run at 1 per cycle.
- Load (legal):
  - mem_wren 0, mem_byteena 1111.
  - Counter loads IO_READ_LATENCY-1 if mem_address[10] = 1, else MEM_READ_LATENCY-1; go to WAIT.
  - At each WAIT edge: if counter = 0, capture mem_q, extract and register the result, set resp_valid = 1, return to IDLE; otherwise decrement.
  - Result: RAM loads respond in the cycle after edge accept+1; IO loads in the cycle after edge accept+2.
- Extraction:
  - Byte = mem_q[8*off +: 8]; halfword = mem_q[16*off[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW returns the full word.
- resp_valid is exactly one cycle wide. resp_rdata and resp_error hold their value until the next response.
- A new request may be accepted in the same cycle resp_valid is high, because the unit is already in IDLE.
- Stores to the IO write window (word address bit 11) are handled identically to RAM stores; decode is the memory block's job.

Test Plan:
1. SW 0xDEADBEEF at 0x100, then LW 0x100 → byteena 1111, addr 0x040, wren for one cycle; load resp_valid 2 cycles after accept, rdata 0xDEADBEEF, error 0.
2. SB 0x80 at 0x103, then LB 0x103 and LBU 0x103 → byteena 1000, data 0x80808080; LB returns 0xFFFFFF80, LBU returns 0x00000080.
3. LH 0x102 with mem_q = 0x8001xxxx → 0xFFFF8001; LHU returns 0x00008001.
4. LW 0x1001 (misaligned) and store with funct3 = 011 → no wren, resp_valid + error 1 one cycle later, rdata 0.
5. LW to word address 0x400 (IO read) with mem_q = 0x3FF presented on the second edge → resp_valid 3 cycles after accept with 0x3FF; req_ready low for 2 cycles.
6. Reset asserted during IO-load WAIT → next cycle state IDLE, req_ready 1, resp_valid never pulses for the aborted load.
